bitwise_accum_n: RTL and testbench

Parametrised, registered successor to the fixed 16-bit bitwise gates in the chip library. It applies one of eight bitwise operations to a pair of WIDTH-bit words per beat. In pointwise mode it emits one result per beat. In reduce mode it folds a framed stream of beats into a single word. Streaming valid/ready interfaces on both sides make it usable between ALU-side datapath stages and memory-mapped test logic.

---
 rtl/bitwise_accum_n_if.sv | 35 +++
 rtl/bitwise_accum_n.sv | 137 +++++++++++++
 tb/tb_bitwise_accum_n.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/bitwise_accum_n_if.sv
// Stream bundle for bitwise_accum_n: operand beats in, results out,
// plus the per-beat control fields and frame status.
interface bitwise_accum_n_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;
  logic [2:0]       op;
  logic             mode;
  logic [1:0]       red_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;
  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, in_last,
    input  op, mode, red_op, out_ready,
    output in_ready, out_valid, out_data,
    output out_count, out_sat, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_last,
    output op, mode, red_op, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_count, out_sat, busy
  );
endinterface

// File: rtl/bitwise_accum_n.sv
// Registered bitwise gate array: per-beat results in pointwise mode,
// or a framed fold of beats into one word in reduce mode.
module bitwise_accum_n #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  bitwise_accum_n_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [0:0]       state;
  logic [2:0]       op_q;
  logic [1:0]       red_q;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sat_q;
  logic             busy_q;
  logic             ov_q;
  logic [WIDTH-1:0] od_q;
  logic [CNT_W-1:0] oc_q;
  logic             os_q;

  logic             accept;
  logic [2:0]       op_use;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] fold;
  logic [CNT_W-1:0] cnt_n;
  logic             sat_n;

  function automatic logic [WIDTH-1:0] bop(
    input logic [2:0]       o,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    case (o)
      3'd0:    bop = a & b;
      3'd1:    bop = a | b;
      3'd2:    bop = a ^ b;
      3'd3:    bop = ~(a & b);
      3'd4:    bop = ~(a | b);
      3'd5:    bop = ~(a ^ b);
      3'd6:    bop = ~a;
      default: bop = a;
    endcase
  endfunction

  // Reserved combiner code 3 folds as XOR.
  function automatic logic [WIDTH-1:0] rop(
    input logic [1:0]       o,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    case (o)
      2'd0:    rop = a & b;
      2'd1:    rop = a | b;
      default: rop = a ^ b;
    endcase
  endfunction

  assign bus.in_ready  = !ov_q || bus.out_ready;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_count = oc_q;
  assign bus.out_sat   = os_q;
  assign bus.busy      = busy_q;

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    op_use = (state == ACCUM) ? op_q : bus.op;
    r      = bop(op_use, bus.in_a, bus.in_b);
    fold   = rop(red_q, acc, r);
    cnt_n  = (cnt == CMAX) ? cnt : cnt + ONE;
    // Flag marks a beat that could not be counted.
    sat_n  = sat_q || (cnt == CMAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      red_q  <= '0;
      acc    <= '0;
      cnt    <= '0;
      sat_q  <= 1'b0;
      busy_q <= 1'b0;
      ov_q   <= 1'b0;
      od_q   <= '0;
      oc_q   <= '0;
      os_q   <= 1'b0;
    end else begin
      if (ov_q && bus.out_ready)
        ov_q <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            if (!bus.mode || bus.in_last) begin
              od_q <= r;
              oc_q <= ONE;
              os_q <= 1'b0;
              ov_q <= 1'b1;
            end else begin
              state  <= ACCUM;
              op_q   <= bus.op;
              red_q  <= bus.red_op;
              acc    <= r;
              cnt    <= ONE;
              sat_q  <= 1'b0;
              busy_q <= 1'b1;
            end
          end
          default: begin
            if (bus.in_last) begin
              od_q   <= fold;
              oc_q   <= cnt_n;
              os_q   <= sat_n;
              ov_q   <= 1'b1;
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              acc   <= fold;
              cnt   <= cnt_n;
              sat_q <= sat_n;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bitwise_accum_n.sv
// Directed bench for bitwise_accum_n: pointwise ops, reduce frames,
// backpressure, mid-frame reset and counter saturation.
module tb_bitwise_accum_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bitwise_accum_n_if #(.WIDTH(16), .CNT_W(8)) bus ();
  bitwise_accum_n_if #(.WIDTH(16), .CNT_W(4)) bus2 ();

  bitwise_accum_n #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  bitwise_accum_n #(.WIDTH(16), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  function automatic logic [15:0] ref_op(
    input int o,
    input logic [15:0] a,
    input logic [15:0] b
  );
    case (o)
      0:       ref_op = a & b;
      1:       ref_op = a | b;
      2:       ref_op = a ^ b;
      3:       ref_op = ~(a & b);
      4:       ref_op = ~(a | b);
      5:       ref_op = ~(a ^ b);
      6:       ref_op = ~a;
      default: ref_op = a;
    endcase
  endfunction

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [2:0] o,
    input logic m,
    input logic [1:0] ro,
    input logic l
  );
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.op = o;
    bus.mode = m;
    bus.red_op = ro;
    bus.in_last = l;
  endtask

  initial begin
    logic [15:0] wa;
    logic [15:0] wb;
    logic [15:0] one16;
    bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0;
    bus.in_last = 0; bus.op = 0; bus.mode = 0;
    bus.red_op = 0; bus.out_ready = 1;
    bus2.in_valid = 0; bus2.in_a = 0; bus2.in_b = 0;
    bus2.in_last = 0; bus2.op = 0; bus2.mode = 0;
    bus2.red_op = 0; bus2.out_ready = 1;
    one16 = 16'h0001;

    tick(); tick();
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data", 32'(bus.out_data), 0);
    chk("rst_count", 32'(bus.out_count), 0);
    chk("rst_sat", 32'(bus.out_sat), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    rst = 0;
    #1;
    chk("rst_ready", 32'(bus.in_ready), 1);

    // pointwise AND
    beat(16'hF0F0, 16'hFF00, 3'd0, 1'b0, 2'd0, 1'b0);
    tick();
    chk("and_valid", 32'(bus.out_valid), 1);
    chk("and_data", 32'(bus.out_data), 32'h0000F000);
    chk("and_count", 32'(bus.out_count), 1);
    chk("and_sat", 32'(bus.out_sat), 0);

    // walking-bit sweep, back-to-back
    for (int o = 0; o < 8; o++) begin
      wa = '0;
      wb = '0;
      for (int k = 0; k < 16; k++) begin
        wa = wa | (one16 << k);
        wb = wb | (one16 << (15 - k));
        beat(wa, wb, 3'(o), 1'b0, 2'd0, 1'b1);
        chk("walk_ready", 32'(bus.in_ready), 1);
        tick();
        chk("walk_valid", 32'(bus.out_valid), 1);
        chk("walk_data", 32'(bus.out_data),
            32'(ref_op(o, wa, wb)));
      end
    end
    bus.in_valid = 0;
    tick();
    chk("drain_valid", 32'(bus.out_valid), 0);

    // XOR reduce of PASS beats; mid-frame op/mode changes ignored
    beat(16'h0001, 16'h0000, 3'd7, 1'b1, 2'd2, 1'b0);
    tick();
    chk("red1_valid", 32'(bus.out_valid), 0);
    chk("red1_busy", 32'(bus.busy), 1);
    beat(16'h0002, 16'h0000, 3'd0, 1'b0, 2'd0, 1'b0);
    tick();
    chk("red2_valid", 32'(bus.out_valid), 0);
    chk("red2_busy", 32'(bus.busy), 1);
    beat(16'h0004, 16'h0000, 3'd0, 1'b0, 2'd0, 1'b1);
    tick();
    chk("red3_valid", 32'(bus.out_valid), 1);
    chk("red3_data", 32'(bus.out_data), 32'h00000007);
    chk("red3_count", 32'(bus.out_count), 3);
    chk("red3_busy", 32'(bus.busy), 0);
    bus.in_valid = 0;
    tick();
    chk("red_drain", 32'(bus.out_valid), 0);

    // backpressure
    bus.out_ready = 0;
    beat(16'h1234, 16'h0000, 3'd7, 1'b0, 2'd0, 1'b0);
    tick();
    chk("bp_load", 32'(bus.out_data), 32'h00001234);
    beat(16'h00FF, 16'h0F0F, 3'd2, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", 32'(bus.in_ready), 0);
      tick();
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_hold", 32'(bus.out_data), 32'h00001234);
      chk("bp_count", 32'(bus.out_count), 1);
    end
    bus.out_ready = 1;
    #1;
    chk("bp_release", 32'(bus.in_ready), 1);
    tick();
    chk("bp_next_valid", 32'(bus.out_valid), 1);
    chk("bp_next_data", 32'(bus.out_data), 32'h00000FF0);
    bus.in_valid = 0;
    tick();
    chk("bp_drain", 32'(bus.out_valid), 0);

    // reset mid-frame
    beat(16'h1111, 16'h2222, 3'd1, 1'b1, 2'd1, 1'b0);
    tick();
    beat(16'h4444, 16'h8888, 3'd1, 1'b1, 2'd1, 1'b0);
    tick();
    chk("mid_busy", 32'(bus.busy), 1);
    bus.in_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    chk("mr_valid", 32'(bus.out_valid), 0);
    chk("mr_busy", 32'(bus.busy), 0);
    chk("mr_data", 32'(bus.out_data), 0);
    chk("mr_count", 32'(bus.out_count), 0);
    beat(16'hAAAA, 16'h0000, 3'd6, 1'b1, 2'd0, 1'b1);
    tick();
    chk("one_valid", 32'(bus.out_valid), 1);
    chk("one_data", 32'(bus.out_data), 32'h00005555);
    chk("one_count", 32'(bus.out_count), 1);
    chk("one_busy", 32'(bus.busy), 0);

    // reserved combiner acts as XOR
    beat(16'h00F0, 16'h0000, 3'd7, 1'b1, 2'd3, 1'b0);
    tick();
    beat(16'h0FF0, 16'h0000, 3'd7, 1'b1, 2'd3, 1'b1);
    tick();
    chk("rsv_data", 32'(bus.out_data), 32'h00000F00);
    chk("rsv_count", 32'(bus.out_count), 2);
    bus.in_valid = 0;
    tick();

    // saturation on the 4-bit counter
    bus2.in_valid = 1;
    bus2.in_a = 16'hFFFF;
    bus2.in_b = 16'hFFFF;
    bus2.op = 3'd1;
    bus2.mode = 1;
    bus2.red_op = 2'd0;
    for (int i = 1; i <= 20; i++) begin
      bus2.in_last = (i == 20);
      tick();
      if (i == 19) begin
        chk("sat_pre_valid", 32'(bus2.out_valid), 0);
        chk("sat_pre_busy", 32'(bus2.busy), 1);
      end
    end
    bus2.in_valid = 0;
    chk("sat_valid", 32'(bus2.out_valid), 1);
    chk("sat_data", 32'(bus2.out_data), 32'h0000FFFF);
    chk("sat_count", 32'(bus2.out_count), 15);
    chk("sat_flag", 32'(bus2.out_sat), 1);
    chk("sat_busy", 32'(bus2.busy), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
